// File: rtl/square_pipelined_if.sv
// Operand/result handshake bundle for the pipelined squarer.
// The master drives operands and out_ready. The slave (the squarer) drives in_ready and the results.
interface square_pipelined_if #(
    parameter int ROOT_BITS = 8
);
    localparam int SQUARE_BITS = 2 * ROOT_BITS;

    logic                   in_valid;
    logic                   in_ready;
    logic [ROOT_BITS-1:0]   root;
    logic [ROOT_BITS:0]     remainder;
    logic                   out_valid;
    logic                   out_ready;
    logic [SQUARE_BITS-1:0] square;
    logic                   rem_err;

    modport master (
        output in_valid, root, remainder, out_ready,
        input  in_ready, out_valid, square, rem_err
    );

    modport slave (
        input  in_valid, root, remainder, out_ready,
        output in_ready, out_valid, square, rem_err
    );
endinterface

// File: rtl/square_pipelined.sv
// Pipelined unsigned squarer: square = root*root + remainder, one shift-add stage per root bit.
// A single global advance signal stalls the whole pipeline when a result is held at the output.
module square_pipelined #(
    parameter int ROOT_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    square_pipelined_if.slave bus
);
    localparam int N  = ROOT_BITS;
    localparam int SB = 2 * ROOT_BITS;

    logic            advance_s;
    logic            in_err_s;
    logic [SB-1:0]   addend_s [1:N-1];

    logic [N-1:0]    valid_r;
    logic [N-1:0]    err_r;
    logic [N-1:0]    root_r   [N-1];
    logic [N:0]      rem_r    [N];
    logic [SB-1:0]   part_r   [N];

    logic            out_valid_r;
    logic [SB-1:0]   square_r;
    logic            rem_err_r;

    assign advance_s    = !out_valid_r || bus.out_ready;
    assign bus.in_ready = advance_s && !reset;
    assign in_err_s     = bus.remainder > {bus.root, 1'b0};

    assign bus.out_valid = out_valid_r;
    assign bus.square    = square_r;
    assign bus.rem_err   = rem_err_r;

    // Shifted root contribution added by each stage k (root bit k selects root << k)
    always_comb begin
        for (int k = 1; k < N; k++) begin
            addend_s[k] = '0;
            if (root_r[k-1][k]) begin
                addend_s[k] = SB'(root_r[k-1]) << k;
            end else begin
                addend_s[k] = '0;
            end
        end
    end

    // Shift-add pipeline; operands, flags and valid bits travel alongside the partial sum
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
            err_r   <= '0;
            for (int k = 0; k < N; k++) begin
                rem_r[k]  <= '0;
                part_r[k] <= '0;
            end
            for (int k = 0; k < N - 1; k++) begin
                root_r[k] <= '0;
            end
        end else if (advance_s) begin
            valid_r   <= {valid_r[N-2:0], bus.in_valid};
            err_r     <= {err_r[N-2:0], in_err_s};
            root_r[0] <= bus.root;
            rem_r[0]  <= bus.remainder;
            part_r[0] <= bus.root[0] ? SB'(bus.root) : '0;
            for (int k = 1; k < N; k++) begin
                rem_r[k]  <= rem_r[k-1];
                part_r[k] <= part_r[k-1] + addend_s[k];
            end
            for (int k = 1; k < N - 1; k++) begin
                root_r[k] <= root_r[k-1];
            end
        end
    end

    // Output stage: remainder add-back; square and rem_err keep their last value across bubbles
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            square_r    <= '0;
            rem_err_r   <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= valid_r[N-1];
            if (valid_r[N-1]) begin
                square_r  <= part_r[N-1] + SB'(rem_r[N-1]);
                rem_err_r <= err_r[N-1];
            end
        end
    end
endmodule

// File: tb/tb_square_pipelined.sv
// Directed bench for square_pipelined: latency, corner values, streaming, backpressure and reset flush.
module tb_square_pipelined;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    square_pipelined_if #(.ROOT_BITS(8)) bus ();

    square_pipelined #(.ROOT_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One isolated operation: no result before edge 9, a one-cycle pulse on edge 9.
    task automatic run_one(input string tag, input int r, input int m, input int exp_sq, input int exp_err);
        bus.root      = 8'(r);
        bus.remainder = 9'(m);
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        for (int i = 2; i <= 8; i++) tick();
        check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_sq"},    32'(bus.square),    32'(exp_sq));
        check({tag, "_err"},   32'(bus.rem_err),   32'(exp_err));
        tick();
        check({tag, "_pulse"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int  next_in;
        int  next_out;
        logic stalled;
        logic [15:0] held;

        total = 0;
        bad   = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.root      = 8'd0;
        bus.remainder = 9'd0;
        bus.out_ready = 1'b1;

        tick();
        tick();
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_square",    32'(bus.square),    32'd0);
        check("rst_rem_err",   32'(bus.rem_err),   32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        run_one("op12",    12,  5,   149,   0);
        run_one("zero",    0,   0,   0,     0);
        run_one("max",     255, 510, 65535, 0);
        run_one("max_r0",  255, 0,   65025, 0);
        run_one("wrap",    255, 511, 0,     1);
        run_one("ill3",    3,   7,   16,    1);

        // Streaming 0..255 back-to-back
        for (int c = 0; c < 264; c++) begin
            if (c < 256) begin
                bus.in_valid  = 1'b1;
                bus.root      = 8'(c);
                bus.remainder = 9'd0;
                #1;
                check("stream_in_ready", 32'(bus.in_ready), 32'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (c >= 8) begin
                check("stream_valid", 32'(bus.out_valid), 32'd1);
                check("stream_sq",    32'(bus.square),    32'((c - 8) * (c - 8)));
            end else begin
                check("stream_early", 32'(bus.out_valid), 32'd0);
            end
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Backpressure: roots 1..20 with random out_ready and a forced 5-cycle stall
        next_in  = 1;
        next_out = 1;
        for (int cyc = 0; cyc < 400 && next_out <= 20; cyc++) begin
            if (cyc >= 12 && cyc < 17) bus.out_ready = 1'b0;
            else                       bus.out_ready = 1'($urandom_range(0, 1));
            if (next_in <= 20) begin
                bus.in_valid  = 1'b1;
                bus.root      = 8'(next_in);
                bus.remainder = 9'd0;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            check("bp_in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            if (bus.out_valid && bus.out_ready) begin
                check("bp_order", 32'(bus.square), 32'(next_out * next_out));
                next_out++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.square;
            if (bus.in_valid && bus.in_ready) next_in++;
            @(posedge clk);
            #1;
            if (stalled) begin
                check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
                check("bp_hold_sq",    32'(bus.square),    32'(held));
            end
        end
        check("bp_count", 32'(next_out), 32'd21);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("bp_no_dup", 32'(bus.out_valid), 32'd0);
        end

        // Reset while roots 7 and 9 are in flight
        bus.in_valid  = 1'b1;
        bus.root      = 8'd7;
        bus.remainder = 9'd0;
        tick();
        bus.root      = 8'd9;
        tick();
        bus.in_valid  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("flush_rst_valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            check("flush_no_result", 32'(bus.out_valid), 32'd0);
        end
        run_one("after_rst", 10, 3, 103, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
